mem_req_scheduler: RTL

Round-robin scheduler that shares one memory request/response port among NUM_REQS requesters, such as per-cluster buses ahead of the L3 or the external memory interface. It arbitrates requests, appends the winner's index to the tag, and routes responses back by that index. It enforces a per-requester cap on outstanding reads and reports busy while any read is in flight.

---
 rtl/mem_req_scheduler_if.sv | 59 +++++
 rtl/mem_req_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_req_scheduler_if.sv
// rtl/mem_req_scheduler_if.sv - requester, response and memory-side signals of the request scheduler
interface mem_req_scheduler_if #(
    parameter int NUM_REQS   = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 8
);
    localparam int REQ_SEL_BITS  = $clog2(NUM_REQS);
    localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8;
    localparam int MEM_TAG_WIDTH = TAG_WIDTH + REQ_SEL_BITS;

    logic [NUM_REQS-1:0]              req_valid;
    logic [NUM_REQS-1:0]              req_rw;
    logic [NUM_REQS*BYTEEN_WIDTH-1:0] req_byteen;
    logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr;
    logic [NUM_REQS*DATA_WIDTH-1:0]   req_data;
    logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag;
    logic [NUM_REQS-1:0]              req_ready;

    logic [NUM_REQS-1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]            rsp_data;
    logic [TAG_WIDTH-1:0]             rsp_tag;
    logic [NUM_REQS-1:0]              rsp_ready;

    logic                             mem_req_valid;
    logic                             mem_req_rw;
    logic [BYTEEN_WIDTH-1:0]          mem_req_byteen;
    logic [ADDR_WIDTH-1:0]            mem_req_addr;
    logic [DATA_WIDTH-1:0]            mem_req_data;
    logic [MEM_TAG_WIDTH-1:0]         mem_req_tag;
    logic                             mem_req_ready;

    logic                             mem_rsp_valid;
    logic [DATA_WIDTH-1:0]            mem_rsp_data;
    logic [MEM_TAG_WIDTH-1:0]         mem_rsp_tag;
    logic                             mem_rsp_ready;

    modport slave (
        input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
        output req_ready,
        output rsp_valid, rsp_data, rsp_tag,
        input  rsp_ready,
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport master (
        output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_tag,
        output rsp_ready,
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/mem_req_scheduler.sv
// rtl/mem_req_scheduler.sv - round-robin memory request scheduler with per-requester read cap (optional MEM_SCHED_PERF_EN stall counters)
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 32
`endif

module mem_req_scheduler #(
    parameter int NUM_REQS    = 4,
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 512,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_req_scheduler_if.slave   bus,
`ifdef MEM_SCHED_PERF_EN
    output logic [NUM_REQS*`PERF_CTR_BITS-1:0] perf_stall_cycles,
`endif
    output logic                 busy
);
    localparam int SEL_BITS = $clog2(NUM_REQS);
    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int MTAG_W   = TAG_WIDTH + SEL_BITS;
    localparam int CNT_W    = $clog2(MAX_PENDING) + 1;

    typedef struct packed {
        logic                  rw;
        logic [BE_W-1:0]       byteen;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [MTAG_W-1:0]     tag;
    } entry_t;

    logic [CNT_W-1:0]    pend_cnt [NUM_REQS];
    logic [NUM_REQS-1:0] eligible, pend_inc, pend_dec, req_ready_int;
    logic [SEL_BITS-1:0] rr_ptr, winner, rsp_sel;
    logic                found, accept, pop, sel_ok, rsp_fire, any_pend;
    logic [1:0]          count;
    entry_t              head, skid, incoming;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQS; i++)
            eligible[i] = bus.req_valid[i] && (bus.req_rw[i] || pend_cnt[i] < CNT_W'(MAX_PENDING));
        for (int k = 1; k <= NUM_REQS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQS;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = SEL_BITS'(idx);
            end
        end
    end

    assign accept = found && (count != 2'd2);
    assign pop    = (count != 2'd0) && bus.mem_req_ready;

    always_comb begin
        req_ready_int         = '0;
        req_ready_int[winner] = accept;
        incoming.rw     = bus.req_rw[winner];
        incoming.byteen = bus.req_byteen[int'(winner)*BE_W +: BE_W];
        incoming.addr   = bus.req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        incoming.data   = bus.req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        incoming.tag    = {winner, bus.req_tag[int'(winner)*TAG_WIDTH +: TAG_WIDTH]};
    end
    assign bus.req_ready = req_ready_int;

    // head is the registered output stage; skid holds the second entry while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            head   <= '0;
            skid   <= '0;
            rr_ptr <= SEL_BITS'(NUM_REQS - 1);
        end else begin
            if (accept)
                rr_ptr <= winner;
            case ({pop, accept})
                2'b01: begin
                    if (count == 2'd0) head <= incoming;
                    else               skid <= incoming;
                    count <= count + 2'd1;
                end
                2'b10: begin
                    if (count == 2'd2) head <= skid;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= skid;
                        skid <= incoming;
                    end else begin
                        head <= incoming;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req_valid  = (count != 2'd0);
    assign bus.mem_req_rw     = head.rw;
    assign bus.mem_req_byteen = head.byteen;
    assign bus.mem_req_addr   = head.addr;
    assign bus.mem_req_data   = head.data;
    assign bus.mem_req_tag    = head.tag;

    // Responses carry the requester index in the tag MSBs; out-of-range indices are swallowed.
    assign rsp_sel = bus.mem_rsp_tag[MTAG_W-1 -: SEL_BITS];
    assign sel_ok  = {1'b0, rsp_sel} < (SEL_BITS+1)'(NUM_REQS);

    always_comb begin
        bus.rsp_valid = '0;
        if (sel_ok)
            bus.rsp_valid[rsp_sel] = bus.mem_rsp_valid;
    end
    assign bus.rsp_data      = bus.mem_rsp_data;
    assign bus.rsp_tag       = bus.mem_rsp_tag[TAG_WIDTH-1:0];
    assign bus.mem_rsp_ready = bus.mem_rsp_valid && (sel_ok ? bus.rsp_ready[rsp_sel] : 1'b1);
    assign rsp_fire          = bus.mem_rsp_valid && bus.mem_rsp_ready && sel_ok;

    always_comb begin
        any_pend = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            pend_inc[i] = accept && (winner == SEL_BITS'(i)) && !incoming.rw;
            pend_dec[i] = rsp_fire && (rsp_sel == SEL_BITS'(i));
            any_pend    = any_pend || (pend_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++)
                pend_cnt[i] <= '0;
        end else begin
            assert (!(bus.mem_rsp_valid && !sel_ok));
            for (int i = 0; i < NUM_REQS; i++) begin
                assert (!(pend_dec[i] && !pend_inc[i] && pend_cnt[i] == '0));
                if (pend_inc[i] && !pend_dec[i])
                    pend_cnt[i] <= pend_cnt[i] + CNT_W'(1);
                else if (pend_dec[i] && !pend_inc[i] && pend_cnt[i] != '0)
                    pend_cnt[i] <= pend_cnt[i] - CNT_W'(1);
            end
        end
    end

    assign busy = any_pend || (count != 2'd0);

`ifdef MEM_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++)
                if (bus.req_valid[i] && !req_ready_int[i])
                    perf_stall_cycles[i*`PERF_CTR_BITS +: `PERF_CTR_BITS] <=
                        perf_stall_cycles[i*`PERF_CTR_BITS +: `PERF_CTR_BITS] + `PERF_CTR_BITS'(1);
        end
    end
`endif
endmodule
